// File: rtl/mandel_frame_sched.sv
// Frame scheduler for a MandelbrotCalc core: walks every pixel of an H_RES x V_RES frame in raster order.
// Optional statistics outputs (busy cycles, peak iteration count) are enabled by defining MANDEL_SCHED_STATS_EN.
module mandel_frame_sched #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x_min,
    input  logic [31:0] y_max,
    input  logic [31:0] step,
    output logic        busy,
    output logic        done,
    output logic [31:0] calc_a,
    output logic [31:0] calc_b,
    output logic        calc_en,
    input  logic        calc_ready,
    input  logic [15:0] calc_iter,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_iter,
    output logic        pix_last
`ifdef MANDEL_SCHED_STATS_EN
    ,
    output logic [31:0] stat_cycles,
    output logic [15:0] stat_max_iter
`endif
);

    localparam logic [15:0] X_LAST = 16'(H_RES - 1);
    localparam logic [15:0] Y_LAST = 16'(V_RES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT,
        OUT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] x_min_q;
    logic [31:0] step_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            calc_en   <= 1'b0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            calc_a    <= '0;
            calc_b    <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_iter  <= '0;
        end else begin
            // NOTE: every state register here uses <= so all of them update from the same pre-edge values.
            calc_en <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // NOTE: x_min_q/step_q are pure datapath and are always loaded before use, so they carry no reset.
                        x_min_q  <= x_min;
                        step_q   <= step;
                        calc_a   <= x_min;
                        calc_b   <= y_max;
                        pix_x    <= '0;
                        pix_y    <= '0;
                        pix_last <= 1'b0;
                        busy     <= 1'b1;
                        calc_en  <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: state <= GUARD;
                // A ready left over from the previous pixel is still visible here, so skip one cycle.
                GUARD: state <= WAIT;
                WAIT: begin
                    if (calc_ready) begin
                        pix_iter  <= calc_iter;
                        pix_valid <= 1'b1;
                        pix_last  <= (pix_x == X_LAST) && (pix_y == Y_LAST);
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        pix_last  <= 1'b0;
                        if (pix_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (pix_x == X_LAST) begin
                            pix_x   <= '0;
                            pix_y   <= pix_y + 16'd1;
                            calc_a  <= x_min_q;
                            calc_b  <= calc_b - step_q;
                            calc_en <= 1'b1;
                            state   <= ISSUE;
                        end else begin
                            pix_x   <= pix_x + 16'd1;
                            calc_a  <= calc_a + step_q;
                            calc_en <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MANDEL_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cycles   <= '0;
            stat_max_iter <= '0;
        end else if (state == IDLE && start) begin
            stat_cycles   <= '0;
            stat_max_iter <= '0;
        end else begin
            if (busy) stat_cycles <= stat_cycles + 32'd1;
            if (state == WAIT && calc_ready && calc_iter > stat_max_iter)
                stat_max_iter <= calc_iter;
        end
    end
`endif

endmodule

// File: tb/tb_mandel_frame_sched.sv
// Scoreboard bench for mandel_frame_sched on a 4x3 frame with a 3-cycle MandelbrotCalc model.
// Build with MANDEL_SCHED_STATS_EN defined to also check the statistics outputs.
module tb_mandel_frame_sched;

    localparam int H = 4;
    localparam int V = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] x_min = '0, y_max = '0, step = '0;
    logic        busy, done, calc_en, calc_ready, pix_valid, pix_last;
    logic        pix_ready = 1'b1;
    logic [31:0] calc_a, calc_b;
    logic [15:0] calc_iter, pix_x, pix_y, pix_iter;
`ifdef MANDEL_SCHED_STATS_EN
    logic [31:0] stat_cycles;
    logic [15:0] stat_max_iter;
`endif

    mandel_frame_sched #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_min(x_min), .y_max(y_max), .step(step),
        .busy(busy), .done(done),
        .calc_a(calc_a), .calc_b(calc_b), .calc_en(calc_en),
        .calc_ready(calc_ready), .calc_iter(calc_iter),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter), .pix_last(pix_last)
`ifdef MANDEL_SCHED_STATS_EN
        , .stat_cycles(stat_cycles), .stat_max_iter(stat_max_iter)
`endif
    );

    always #5 clk = ~clk;

    // MandelbrotCalc model: ready drops on en and returns 3 cycles later; iterations count 1,2,3... per frame.
    logic [1:0]  cnt;
    logic [15:0] next_iter, cur_iter;
    logic        hold_ready = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            next_iter <= 16'd1;
            cur_iter  <= '0;
        end else begin
            if (start && !busy) next_iter <= 16'd1;
            else if (calc_en) begin
                cur_iter  <= next_iter;
                next_iter <= next_iter + 16'd1;
            end
            if (calc_en) cnt <= 2'd3;
            else if (cnt != 0) cnt <= cnt - 2'd1;
        end
    end
    assign calc_ready = hold_ready || (cnt == 2'd0);
    assign calc_iter  = cur_iter;

    typedef struct {
        logic [15:0] x, y;
        logic [31:0] a, b;
        logic [15:0] iter;
        logic        last;
    } pix_t;

    pix_t q[$];
    int   n_tests = 0, n_fail = 0;
    int   busy_cnt = 0, done_cnt = 0, pix_cnt = 0;
    bit   en_pending = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic build_frame(input logic [31:0] xm, input logic [31:0] ym, input logic [31:0] st);
        pix_t e;
        q.delete();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                e.x    = 16'(x);
                e.y    = 16'(y);
                e.a    = xm + st * 32'(x);
                e.b    = ym - st * 32'(y);
                e.iter = 16'(y * H + x + 1);
                e.last = (x == H - 1) && (y == V - 1);
                q.push_back(e);
            end
        busy_cnt   = 0;
        done_cnt   = 0;
        pix_cnt    = 0;
        en_pending = 1'b0;
    endtask

    // Monitor: calc_en checked against the pixel at the queue head, accepted pixels popped and compared.
    always @(negedge clk) begin
        pix_t e;
        if (!rst) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (calc_en) begin
                check("calc_en_once", 32'(en_pending), 32'd0);
                check("calc_en_has_pixel", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    check("calc_a", calc_a, q[0].a);
                    check("calc_b", calc_b, q[0].b);
                end
                en_pending = 1'b1;
            end
            if (pix_valid && pix_ready) begin
                check("pix_has_expected", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("pix_x", 32'(pix_x), 32'(e.x));
                    check("pix_y", 32'(pix_y), 32'(e.y));
                    check("pix_iter", 32'(pix_iter), 32'(e.iter));
                    check("pix_last", 32'(pix_last), 32'(e.last));
                    check("pix_had_en", 32'(en_pending), 32'd1);
                    pix_cnt++;
                end
                en_pending = 1'b0;
            end
        end
    end

    task automatic start_frame(input logic [31:0] xm, input logic [31:0] ym, input logic [31:0] st);
        @(negedge clk);
        x_min = xm;
        y_max = ym;
        step  = st;
        build_frame(xm, ym, st);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_calc_en", 32'(calc_en), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_calc_a", calc_a, xm);
        check("start_calc_b", calc_b, ym);
    endtask

    task automatic wait_en_at(input int x, input int y);
        bit hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (calc_en && q.size() > 0 && q[0].x == 16'(x) && q[0].y == 16'(y)) hit = 1'b1;
        end
        check("reach_pixel", 32'(hit), 32'd1);
    endtask

    task automatic wait_done();
        bit hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (done) hit = 1'b1;
        end
        check("done_seen", 32'(hit), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_end_checks();
        check("pixel_count", 32'(pix_cnt), 32'(H * V));
        check("done_count", 32'(done_cnt), 32'd1);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] hold_iter;
        bit          got_valid;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_calc_en", 32'(calc_en), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_last", 32'(pix_last), 32'd0);
        check("rst_calc_a", calc_a, 32'd0);
        check("rst_calc_b", calc_b, 32'd0);
        check("rst_pix_xy", {pix_x, pix_y}, 32'd0);
        check("rst_pix_iter", 32'(pix_iter), 32'd0);
`ifdef MANDEL_SCHED_STATS_EN
        check("rst_stat_cycles", stat_cycles, 32'd0);
        check("rst_stat_max", 32'(stat_max_iter), 32'd0);
`endif
        rst = 1'b0;

        // Frame 1: plain run; inputs changed and a stray start issued mid-frame must be ignored
        start_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000);
        x_min = 32'h1234_5678;
        y_max = 32'h0BAD_0000;
        step  = 32'h0001_0000;
        wait_en_at(1, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        frame_end_checks();
`ifdef MANDEL_SCHED_STATS_EN
        check("stat_cycles", stat_cycles, 32'(busy_cnt));
        check("stat_max_iter", 32'(stat_max_iter), 32'd12);
`endif

        // Frame 2: calc_ready stuck high; minimum 4 cycles per pixel plus DONE
        hold_ready = 1'b1;
        start_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000);
        wait_done();
        frame_end_checks();
        check("min_cycles_busy", 32'(busy_cnt), 32'(H * V * 4 + 1));
`ifdef MANDEL_SCHED_STATS_EN
        check("stat_cycles_min", stat_cycles, 32'(H * V * 4 + 1));
`endif
        hold_ready = 1'b0;

        // Frame 3: backpressure on pixel (2,1)
        start_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000);
        wait_en_at(2, 1);
        pix_ready = 1'b0;
        hold_iter = q[0].iter;
        got_valid = 1'b0;
        for (int i = 0; i < 200 && !got_valid; i++) begin
            @(negedge clk);
            if (pix_valid) got_valid = 1'b1;
        end
        check("stall_valid_seen", 32'(got_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(pix_valid), 32'd1);
            check("stall_xy", {pix_x, pix_y}, {16'd2, 16'd1});
            check("stall_iter", 32'(pix_iter), 32'(hold_iter));
            check("stall_last", 32'(pix_last), 32'd0);
            check("stall_no_en", 32'(calc_en), 32'd0);
            @(negedge clk);
        end
        pix_ready = 1'b1;
        wait_done();
        frame_end_checks();

        // Frame 4: reset during pixel (1,1), restart on the first cycle out of reset with x_min=0
        start_frame(32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000);
        wait_en_at(1, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_calc_en", 32'(calc_en), 32'd0);
        check("abort_pix_valid", 32'(pix_valid), 32'd0);
        check("abort_calc_a", calc_a, 32'd0);
        @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        rst   = 1'b0;
        x_min = 32'h0;
        y_max = 32'h0001_0000;
        step  = 32'h0000_8000;
        build_frame(32'h0, 32'h0001_0000, 32'h0000_8000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_calc_en", 32'(calc_en), 32'd1);
        check("restart_calc_a", calc_a, 32'd0);
        wait_en_at(2, 0);
        x_min = 32'h1111_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        frame_end_checks();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mandel_frame_sched.md
MANDEL_FRAME_SCHED -- requirements
Module: mandel_frame_sched

Interface
REQ-001 SHALL have parameter H_RES, default 640: pixels per line, range 2..65535.
REQ-002 SHALL have parameter V_RES, default 480: lines per frame, range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to render one frame.
REQ-006 SHALL have ports x_min, y_max and step, each input, 32 bits, signed Q15.16: left-edge real part, top-edge imaginary part and per-pixel increment.
REQ-007 SHALL have port busy, output, 1 bit: frame in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse after the last pixel is accepted.
REQ-009 SHALL have ports calc_a and calc_b, output, 32 bits, signed Q15.16: c value driven to the MandelbrotCalc initial_a and initial_b inputs.
REQ-010 SHALL have port calc_en, output, 1 bit: one-cycle start pulse to MandelbrotCalc en.
REQ-011 SHALL have port calc_ready, input, 1 bit: MandelbrotCalc ready.
REQ-012 SHALL have port calc_iter, input, 16 bits: MandelbrotCalc iterations.
REQ-013 SHALL have port pix_valid, output, 1 bit: pixel result available.
REQ-014 SHALL have port pix_ready, input, 1 bit: downstream accepts the pixel.
REQ-015 SHALL have ports pix_x and pix_y, output, 16 bits each: pixel column and row.
REQ-016 SHALL have port pix_iter, output, 16 bits: iteration count for the pixel.
REQ-017 SHALL have port pix_last, output, 1 bit: set with the pixel at (H_RES-1, V_RES-1).

Function
REQ-018 SHALL implement the FSM states IDLE, ISSUE, GUARD, WAIT, OUT and DONE.
REQ-019 IDLE: start=1 SHALL latch x_min, y_max and step, set x=0, y=0, calc_a=x_min, calc_b=y_max, and go to ISSUE. Start arriving in any other state SHALL be ignored.
REQ-020 ISSUE: SHALL assert calc_en for exactly one cycle, then go to GUARD.
REQ-021 GUARD: SHALL ignore calc_ready for one cycle, so a stale ready from the previous pixel is not taken, then go to WAIT.
REQ-022 WAIT: calc_ready=1 SHALL capture calc_iter into pix_iter and go to OUT. No timeout applies.
REQ-023 calc_a and calc_b SHALL stay stable from ISSUE until WAIT exits.
REQ-024 OUT: SHALL hold pix_valid=1 with pix_x, pix_y, pix_iter and pix_last stable until pix_ready=1. The AXI-style rule applies: pix_valid is never withdrawn before acceptance.
REQ-025 On acceptance when not last: x SHALL increment and calc_a += step, then go to ISSUE.
REQ-026 On acceptance when x=H_RES-1 (line wrap): SHALL set x=0, y+=1, calc_a=latched x_min, calc_b -= step, then go to ISSUE.
REQ-027 On acceptance of the last pixel: SHALL go to DONE. DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Coordinate arithmetic SHALL be 32-bit two's complement with wrap-around (no saturation). The bit-exact increment is the only required result.
REQ-030 The minimum cost per pixel SHALL be 4 cycles (ISSUE, GUARD, WAIT with immediate ready, OUT with immediate pix_ready).
REQ-031 Changes on x_min, y_max or step during busy SHALL have no effect on the current frame.

Reset
REQ-032 rst=1 SHALL force state IDLE and set busy=0, done=0, calc_en=0, pix_valid=0, pix_last=0, calc_a, calc_b, pix_x, pix_y and pix_iter all to 0.
REQ-033 rst asserted mid-frame SHALL abandon the frame with no done pulse. The first cycle after rst deasserts SHALL accept start.

Configuration
REQ-034 With macro MANDEL_SCHED_STATS_EN defined, the block SHALL add two outputs:
- stat_cycles, 32 bits: counts cycles while busy=1; cleared on frame start; holds after done.
- stat_max_iter, 16 bits: largest calc_iter captured in the frame; cleared on frame start.
Both SHALL reset to 0.
REQ-035 Without MANDEL_SCHED_STATS_EN, these ports and their logic SHALL be absent. All other behaviour SHALL be identical.

Verification
Bench setup: H_RES=4, V_RES=3, x_min=0xFFFE0000, y_max=0x00010000, step=0x00008000, calc model returns ready 3 cycles after en.
REQ-036 Start pulse -> calc_en the next cycle with calc_a=0xFFFE0000, calc_b=0x00010000; busy=1.
REQ-037 Full frame with pix_ready=1 -> exactly 12 pixels in raster order; pixel (1,0) has calc_a=0xFFFE8000; pixel (0,1) has calc_a=0xFFFE0000, calc_b=0x00008000; pixel (3,2) has calc_a=0xFFFF8000, calc_b=0 and pix_last=1; then done pulses once.
REQ-038 calc_ready held at 1 continuously -> GUARD prevents reuse; exactly one calc_en per pixel; 12 pixels total.
REQ-039 pix_ready=0 for 5 cycles on pixel (2,1) -> pix_valid and payload stable throughout; no calc_en until acceptance.
REQ-040 rst during pixel (1,1), then a new start with x_min=0 -> first calc_a=0; no done pulse from the aborted frame; second start during busy is ignored.
REQ-041 With MANDEL_SCHED_STATS_EN and calc_iter sequence 1..12 -> stat_max_iter=12 and stat_cycles equal to the counted busy cycles.
